// File: rtl/truth_table_sweeper_pkg.sv
// sweep_pkg: shared types and constants for the truth-table sweeper.
//   state_t     : FSM encoding (IDLE/APPLY/SAMPLE/DONE)
//   MAX_VARS_DEF: default maximum number of input variables
//   SETTLE_W    : width of the settle down-counter (SETTLE up to 15)
//   nvars_legal : range check for a requested variable count
package sweep_pkg;

    localparam int MAX_VARS_DEF = 4;
    localparam int SETTLE_W     = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic logic nvars_legal(input logic [2:0] n, input int max_vars);
        return (n != 3'd0) && (int'({1'b0, n}) <= max_vars);
    endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// truth_table_sweeper_if: control and result bus of the sweeper.
//   master: controller side (drives start/nvars and the SOP/POS outputs
//           of the functions under test, observes vec_out and results)
//   slave : the sweeper itself
interface truth_table_sweeper_if
    import sweep_pkg::*;
#(
    parameter int MAX_VARS = MAX_VARS_DEF
) ();
    logic                       start;
    logic [2:0]                 nvars;
    logic [MAX_VARS-1:0]        vec_out;
    logic                       sop_in;
    logic                       pos_in;
    logic                       busy;
    logic                       done;
    logic                       cfg_err;
    logic [(1<<MAX_VARS)-1:0]   minterms;
    logic [MAX_VARS:0]          mismatch_cnt;
    logic                       mismatch_flag;
    logic [MAX_VARS-1:0]        first_mis;

    modport master (
        output start, nvars, sop_in, pos_in,
        input  vec_out, busy, done, cfg_err, minterms, mismatch_cnt,
               mismatch_flag, first_mis
    );

    modport slave (
        input  start, nvars, sop_in, pos_in,
        output vec_out, busy, done, cfg_err, minterms, mismatch_cnt,
               mismatch_flag, first_mis
    );
endinterface

// File: rtl/truth_table_sweeper_index_counter.sv
// sweep_index_counter: vector index plus per-vector settle down-counter.
//   clk, rst_n  : clock, async active-low reset
//   load_i      : start of sweep - index to 0, settle reloaded
//   step_i      : advance to next vector - index+1, settle reloaded
//   clr_i       : end of sweep - index and settle back to 0
//   nvars_i     : latched variable count (for the last-index compare)
//   index_o     : current vector index
//   settle_tc_o : settle counter expired (APPLY may move on)
//   last_o      : index is 2**nvars-1
module sweep_index_counter
    import sweep_pkg::*;
#(
    parameter int MAX_VARS = MAX_VARS_DEF,
    parameter int SETTLE   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_i,
    input  logic                step_i,
    input  logic                clr_i,
    input  logic [2:0]          nvars_i,
    output logic [MAX_VARS-1:0] index_o,
    output logic                settle_tc_o,
    output logic                last_o
);
    // Reload with SETTLE-1 so APPLY lasts exactly SETTLE cycles, counting
    // the cycle in which the counter reads zero.
    localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE - 1);

    logic [MAX_VARS-1:0] index_q, index_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [MAX_VARS:0]   top_idx;

    always_comb begin
        index_d  = index_q;
        settle_d = settle_q;
        if (clr_i) begin
            index_d  = '0;
            settle_d = '0;
        end else if (load_i) begin
            index_d  = '0;
            settle_d = SETTLE_LD;
        end else if (step_i) begin
            index_d  = index_q + 1'b1;
            settle_d = SETTLE_LD;
        end else if (settle_q != '0) begin
            settle_d = settle_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index_q  <= '0;
            settle_q <= '0;
        end else begin
            index_q  <= index_d;
            settle_q <= settle_d;
        end
    end

    assign top_idx     = (MAX_VARS+1)'((1 << nvars_i) - 1);
    assign last_o      = ({1'b0, index_q} == top_idx);
    assign settle_tc_o = (settle_q == '0);
    assign index_o     = index_q;

endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: walks every input vector of an nvars-input function,
// feeds it to SOP and POS implementations, records the SOP minterm mask and
// counts SOP/POS disagreements.
//   clk, rst_n : clock, async active-low reset (aborts a sweep, no done)
//   bus        : truth_table_sweeper_if.slave (start/nvars/sop_in/pos_in in;
//                vec_out/busy/done/cfg_err/minterms/mismatch_* out)
// Build option: SWEEP_STOP_ON_MISMATCH_EN ends the sweep at the first
// mismatching vector instead of completing it.
module truth_table_sweeper
    import sweep_pkg::*;
#(
    parameter int MAX_VARS = MAX_VARS_DEF,
    parameter int SETTLE   = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    truth_table_sweeper_if.slave    bus
);
    state_t                     state_q;
    logic [2:0]                 nvars_q;
    logic [MAX_VARS-1:0]        vec_q;
    logic                       busy_q, done_q, cfg_err_q;
    logic [(1<<MAX_VARS)-1:0]   minterms_q;
    logic [MAX_VARS:0]          mis_cnt_q;
    logic                       mis_flag_q;
    logic [MAX_VARS-1:0]        first_mis_q;

    logic [MAX_VARS-1:0]        index;
    logic                       settle_tc, last, mis, start_ok, end_sweep;
    logic                       cnt_load, cnt_step, cnt_clr;

    assign start_ok = nvars_legal(bus.nvars, MAX_VARS);
    assign mis      = bus.sop_in ^ bus.pos_in;

`ifdef SWEEP_STOP_ON_MISMATCH_EN
    assign end_sweep = last | mis;
`else
    assign end_sweep = last;
`endif

    assign cnt_load = (state_q == IDLE) && bus.start && start_ok;
    assign cnt_step = (state_q == SAMPLE) && !end_sweep;
    assign cnt_clr  = (state_q == SAMPLE) && end_sweep;

    sweep_index_counter #(
        .MAX_VARS (MAX_VARS),
        .SETTLE   (SETTLE)
    ) u_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (cnt_load),
        .step_i      (cnt_step),
        .clr_i       (cnt_clr),
        .nvars_i     (nvars_q),
        .index_o     (index),
        .settle_tc_o (settle_tc),
        .last_o      (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            nvars_q     <= '0;
            vec_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            minterms_q  <= '0;
            mis_cnt_q   <= '0;
            mis_flag_q  <= 1'b0;
            first_mis_q <= '0;
        end else begin
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (start_ok) begin
                            nvars_q     <= bus.nvars;
                            vec_q       <= '0;
                            busy_q      <= 1'b1;
                            minterms_q  <= '0;
                            mis_cnt_q   <= '0;
                            mis_flag_q  <= 1'b0;
                            first_mis_q <= '0;
                            state_q     <= APPLY;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                end
                APPLY: begin
                    if (settle_tc) state_q <= SAMPLE;
                end
                SAMPLE: begin
                    minterms_q[index] <= bus.sop_in;
                    if (mis) begin
                        mis_cnt_q <= mis_cnt_q + 1'b1;
                        if (!mis_flag_q) begin
                            mis_flag_q  <= 1'b1;
                            first_mis_q <= index;
                        end
                    end
                    if (end_sweep) begin
                        vec_q   <= '0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        vec_q   <= index + 1'b1;
                        state_q <= APPLY;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.vec_out       = vec_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.cfg_err       = cfg_err_q;
    assign bus.minterms      = minterms_q;
    assign bus.mismatch_cnt  = mis_cnt_q;
    assign bus.mismatch_flag = mis_flag_q;
    assign bus.first_mis     = first_mis_q;

endmodule
